pitch_tracker: RTL



---
 rtl/pitch_tracker.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pitch_tracker.sv
// Pitch tracker: voicing gate, median-of-3 period filter and restoring divider
// that turns the filtered period into a fixed-point frequency.
module pitch_tracker #(
    parameter int unsigned TAU_WIDTH     = 11,
    parameter int unsigned SAMPLE_RATE   = 48000,
    parameter int unsigned FRAC_BITS     = 4,
    parameter int unsigned FREQ_WIDTH    = 16,
    parameter int unsigned TAU_MIN       = 20,
    parameter int unsigned UNVOICED_HOLD = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [TAU_WIDTH-1:0]  tau_in,
    input  logic                  valid_in,
    output logic [FREQ_WIDTH-1:0] freq_out,
    output logic [TAU_WIDTH-1:0]  tau_filt_out,
    output logic                  voiced_out,
    output logic                  valid_out,
    output logic                  busy_out,
    output logic                  drop_out
);

    localparam int unsigned NUM_WIDTH  = $clog2(SAMPLE_RATE) + FRAC_BITS;
    localparam int unsigned STEP_WIDTH = $clog2(NUM_WIDTH + 1);
    localparam int unsigned UNV_WIDTH  = $clog2(UNVOICED_HOLD + 1);
    localparam logic [NUM_WIDTH-1:0] NUMERATOR = NUM_WIDTH'(SAMPLE_RATE << FRAC_BITS);
    localparam logic [NUM_WIDTH-1:0] FREQ_MAX  = NUM_WIDTH'((64'd1 << FREQ_WIDTH) - 64'd1);
    localparam logic [UNV_WIDTH-1:0] UNV_HOLD  = UNV_WIDTH'(UNVOICED_HOLD);

    typedef enum logic [1:0] {S_IDLE, S_MEDIAN, S_DIVIDE, S_DONE} state_t;

    state_t                r_state;
    logic [TAU_WIDTH-1:0]  r_hist [3];
    logic [1:0]            r_count;
    logic [UNV_WIDTH-1:0]  r_unv;
    logic                  r_voiced_path;
    logic [NUM_WIDTH-1:0]  r_rem;
    logic [NUM_WIDTH-1:0]  r_quot;
    logic [TAU_WIDTH-1:0]  r_div;
    logic [STEP_WIDTH-1:0] r_step;
    logic [FREQ_WIDTH-1:0] r_freq;
    logic [TAU_WIDTH-1:0]  r_tau_filt;
    logic                  r_voiced;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_drop;

    logic                  w_is_voiced;
    logic [UNV_WIDTH-1:0]  w_unv_inc;
    logic [TAU_WIDTH-1:0]  w_lo;
    logic [TAU_WIDTH-1:0]  w_hi;
    logic [TAU_WIDTH-1:0]  w_mid;
    logic [TAU_WIDTH-1:0]  w_med;
    logic [TAU_WIDTH-1:0]  w_sel;
    logic [NUM_WIDTH-1:0]  w_trial;
    logic                  w_fits;

    // Voicing decision, saturating unvoiced count, median and one divider step.
    always_comb begin
        w_is_voiced = (tau_in >= TAU_WIDTH'(TAU_MIN));
        w_unv_inc   = (r_unv == UNV_HOLD) ? r_unv : r_unv + UNV_WIDTH'(1);
        w_lo        = (r_hist[0] < r_hist[1]) ? r_hist[0] : r_hist[1];
        w_hi        = (r_hist[0] < r_hist[1]) ? r_hist[1] : r_hist[0];
        w_mid       = (w_hi < r_hist[2]) ? w_hi : r_hist[2];
        w_med       = (w_lo > w_mid) ? w_lo : w_mid;
        w_sel       = (r_count == 2'd3) ? w_med : r_hist[0];
        w_trial     = {r_rem[NUM_WIDTH-2:0], r_quot[NUM_WIDTH-1]};
        w_fits      = (w_trial >= NUM_WIDTH'(r_div));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= S_IDLE;
            for (int i = 0; i < 3; i++) r_hist[i] <= '0;
            r_count       <= '0;
            r_unv         <= '0;
            r_voiced_path <= 1'b0;
            r_rem         <= '0;
            r_quot        <= '0;
            r_div         <= '0;
            r_step        <= '0;
            r_freq        <= '0;
            r_tau_filt    <= '0;
            r_voiced      <= 1'b0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_drop  <= valid_in && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_busy <= 1'b1;
                        if (w_is_voiced) begin
                            r_hist[2]     <= r_hist[1];
                            r_hist[1]     <= r_hist[0];
                            r_hist[0]     <= tau_in;
                            r_count       <= (r_count == 2'd3) ? 2'd3 : r_count + 2'd1;
                            r_unv         <= '0;
                            r_voiced_path <= 1'b1;
                            r_state       <= S_MEDIAN;
                        end else begin
                            r_unv         <= w_unv_inc;
                            r_voiced_path <= 1'b0;
                            if (w_unv_inc == UNV_HOLD) begin
                                for (int i = 0; i < 3; i++) r_hist[i] <= '0;
                                r_count <= '0;
                            end
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MEDIAN: begin
                    r_tau_filt <= w_sel;
                    r_div      <= w_sel;
                    r_rem      <= '0;
                    r_quot     <= NUMERATOR;
                    r_step     <= STEP_WIDTH'(NUM_WIDTH);
                    r_state    <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    // Numerator bits shift out of r_quot as quotient bits shift in.
                    r_rem  <= w_fits ? (w_trial - NUM_WIDTH'(r_div)) : w_trial;
                    r_quot <= {r_quot[NUM_WIDTH-2:0], w_fits};
                    r_step <= r_step - STEP_WIDTH'(1);
                    if (r_step == STEP_WIDTH'(1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (r_voiced_path) begin
                        r_freq   <= (r_quot > FREQ_MAX) ? '1 : FREQ_WIDTH'(r_quot);
                        r_voiced <= 1'b1;
                    end else if (r_unv == UNV_HOLD) begin
                        r_freq     <= '0;
                        r_tau_filt <= '0;
                        r_voiced   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign freq_out     = r_freq;
    assign tau_filt_out = r_tau_filt;
    assign voiced_out   = r_voiced;
    assign valid_out    = r_valid;
    assign busy_out     = r_busy;
    assign drop_out     = r_drop;

endmodule
